rob_ctrl: RTL and testbench

- Pointer and sequencing controller for the reorder buffer written by rename and read at commit.
- Allocates up to FETCH_WIDTH ROB slots per cycle; these are the pdst values carried in rename_data_t.
- Tracks per-entry complete and pd_fail flags from writeback, and retires up to COMMIT_WIDTH entries in order.
- Sequences a one-cycle pipeline flush when a mispredicted branch commits. ROB payload RAM stays external; this block only produces indices and strobes.

---
 rtl/rob_ctrl_pkg.sv | 16 +
 rtl/rob_commit_sel.sv | 26 ++
 rtl/rob_ctrl.sv | 111 +++++++++++
 tb/tb_rob_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/rob_ctrl_pkg.sv
// rob_ctrl_pkg: shared ROB geometry, pointer types, writeback request and controller state.
package rob_ctrl_pkg;
  localparam int FETCH_WIDTH  = 2;
  localparam int COMMIT_WIDTH = 2;
  localparam int WB_PORTS     = 4;
  localparam int ROB_DEPTH    = 32;
  localparam int PTR_W        = $clog2(ROB_DEPTH);
  typedef logic [PTR_W-1:0] rob_ptr_t;
  typedef logic [PTR_W:0] rob_wptr_t;
  typedef struct packed {
    logic     valid;
    rob_ptr_t ptr;
    logic     pd_fail;
  } rob_wb_req_t;
  typedef enum logic {NORMAL, FLUSH} rob_state_e;
endpackage

// File: rtl/rob_commit_sel.sv
// rob_commit_sel: in-order retirement selection over the head window; stops after a mispredicted slot.
module rob_commit_sel
  import rob_ctrl_pkg::*;
(
  input  logic [COMMIT_WIDTH-1:0] complete,
  input  logic [COMMIT_WIDTH-1:0] pd_fail,
  input  rob_wptr_t               count,
  input  logic                    stall,
  output logic [COMMIT_WIDTH-1:0] commit_valid,
  output rob_wptr_t               commit_cnt,
  output logic                    flush_req
);
  logic go;
  always_comb begin
    commit_valid = '0;
    commit_cnt = '0;
    flush_req = 1'b0;
    go = !stall;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      commit_valid[i] = go && (rob_wptr_t'(i) < count) && complete[i];
      go = commit_valid[i] && !pd_fail[i];
      flush_req = flush_req || (commit_valid[i] && pd_fail[i]);
      commit_cnt = commit_cnt + rob_wptr_t'(commit_valid[i]);
    end
  end
endmodule

// File: rtl/rob_ctrl.sv
// rob_ctrl: ROB head/tail pointers, completion flags, in-order commit and one-cycle flush sequencing.
// Define ROB_CTRL_PERF_EN to add saturating perf_commits/perf_flushes/perf_full_cycles counters.
module rob_ctrl
  import rob_ctrl_pkg::*;
(
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [FETCH_WIDTH-1:0]        alloc_valid,
  output logic                          alloc_ready,
  output logic [FETCH_WIDTH*PTR_W-1:0]  alloc_ptr,
  input  logic [WB_PORTS-1:0]           wb_valid,
  input  logic [WB_PORTS*PTR_W-1:0]     wb_ptr,
  input  logic [WB_PORTS-1:0]           wb_pd_fail,
  input  logic                          commit_stall,
  output logic [COMMIT_WIDTH*PTR_W-1:0] head_ptr,
  output logic [COMMIT_WIDTH-1:0]       commit_valid,
  output logic                          flush,
  output rob_wptr_t                     count
`ifdef ROB_CTRL_PERF_EN
  ,
  output logic [31:0]                   perf_commits,
  output logic [31:0]                   perf_flushes,
  output logic [31:0]                   perf_full_cycles
`endif
);
  rob_state_e state;
  rob_wptr_t head, tail, alloc_n, commit_cnt;
  logic [ROB_DEPTH-1:0] complete, pd_fail;
  logic [COMMIT_WIDTH-1:0] hd_complete, hd_pd_fail;
  rob_wb_req_t wb [WB_PORTS];
  logic [WB_PORTS-1:0] wb_hit;
  logic alloc_fire, flush_req;
  assign count = tail - head;
  assign flush = state == FLUSH;
  assign alloc_ready = !flush && count <= rob_wptr_t'(ROB_DEPTH - FETCH_WIDTH);
  assign alloc_fire = alloc_ready && |alloc_valid;
  // Valid slots are compacted onto consecutive entries starting at tail.
  always_comb begin
    alloc_n = '0;
    alloc_ptr = '0;
    head_ptr = '0;
    hd_complete = '0;
    hd_pd_fail = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      alloc_ptr[i*PTR_W +: PTR_W] = tail[PTR_W-1:0] + alloc_n[PTR_W-1:0];
      alloc_n = alloc_n + rob_wptr_t'(alloc_valid[i]);
    end
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      head_ptr[i*PTR_W +: PTR_W] = head[PTR_W-1:0] + rob_ptr_t'(i);
      hd_complete[i] = complete[head[PTR_W-1:0] + rob_ptr_t'(i)];
      hd_pd_fail[i] = pd_fail[head[PTR_W-1:0] + rob_ptr_t'(i)];
    end
    for (int k = 0; k < WB_PORTS; k++) begin
      wb[k] = '{valid: wb_valid[k], ptr: wb_ptr[k*PTR_W +: PTR_W], pd_fail: wb_pd_fail[k]};
      wb_hit[k] = wb[k].valid && ({1'b0, rob_ptr_t'(wb[k].ptr - head[PTR_W-1:0])} < count);
    end
  end
  rob_commit_sel u_sel (
    .complete     (hd_complete),
    .pd_fail      (hd_pd_fail),
    .count        (count),
    .stall        (commit_stall || flush),
    .commit_valid (commit_valid),
    .commit_cnt   (commit_cnt),
    .flush_req    (flush_req)
  );
  // Allocation clears are applied after writeback sets so a colliding allocation wins.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= NORMAL;
      head <= '0;
      tail <= '0;
      complete <= '0;
      pd_fail <= '0;
    end else if (flush) begin
      state <= NORMAL;
      tail <= head;
      complete <= '0;
      pd_fail <= '0;
    end else begin
      state <= flush_req ? FLUSH : NORMAL;
      head <= head + commit_cnt;
      if (alloc_fire) tail <= tail + alloc_n;
      for (int k = 0; k < WB_PORTS; k++)
        if (wb_hit[k]) begin
          complete[wb[k].ptr] <= 1'b1;
          if (wb[k].pd_fail) pd_fail[wb[k].ptr] <= 1'b1;
        end
      for (int i = 0; i < FETCH_WIDTH; i++)
        if (alloc_fire && alloc_valid[i]) begin
          complete[alloc_ptr[i*PTR_W +: PTR_W]] <= 1'b0;
          pd_fail[alloc_ptr[i*PTR_W +: PTR_W]] <= 1'b0;
        end
    end
  end
`ifdef ROB_CTRL_PERF_EN
  logic [32:0] commits_sum;
  assign commits_sum = {1'b0, perf_commits} + 33'(commit_cnt);
  always_ff @(posedge clk) begin
    if (!resetn) begin
      perf_commits <= '0;
      perf_flushes <= '0;
      perf_full_cycles <= '0;
    end else begin
      perf_commits <= commits_sum[32] ? '1 : commits_sum[31:0];
      if (flush && perf_flushes != '1) perf_flushes <= perf_flushes + 32'd1;
      if (count == rob_wptr_t'(ROB_DEPTH) && perf_full_cycles != '1) perf_full_cycles <= perf_full_cycles + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_rob_ctrl.sv
// tb_rob_ctrl: directed checks of allocation, compaction, commit, full/wrap, flush, stall and reset.
module tb_rob_ctrl;
  import rob_ctrl_pkg::*;
  logic clk = 1'b0;
  logic resetn;
  logic [FETCH_WIDTH-1:0] alloc_valid;
  logic alloc_ready;
  logic [FETCH_WIDTH*PTR_W-1:0] alloc_ptr;
  logic [WB_PORTS-1:0] wb_valid, wb_pd_fail;
  logic [WB_PORTS*PTR_W-1:0] wb_ptr;
  logic commit_stall;
  logic [COMMIT_WIDTH*PTR_W-1:0] head_ptr;
  logic [COMMIT_WIDTH-1:0] commit_valid;
  logic flush;
  rob_wptr_t count;
  int n_tests = 0;
  int n_fail = 0;
  rob_ctrl dut (
    .clk          (clk),
    .resetn       (resetn),
    .alloc_valid  (alloc_valid),
    .alloc_ready  (alloc_ready),
    .alloc_ptr    (alloc_ptr),
    .wb_valid     (wb_valid),
    .wb_ptr       (wb_ptr),
    .wb_pd_fail   (wb_pd_fail),
    .commit_stall (commit_stall),
    .head_ptr     (head_ptr),
    .commit_valid (commit_valid),
    .flush        (flush),
    .count        (count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wb_set(input int k, input int p, input logic f);
    wb_valid[k] = 1'b1;
    wb_ptr[k*PTR_W +: PTR_W] = rob_ptr_t'(p);
    wb_pd_fail[k] = f;
  endtask
  task automatic wb_clr();
    wb_valid = '0;
    wb_ptr = '0;
    wb_pd_fail = '0;
  endtask
  function automatic int ap(input int i);
    return int'(alloc_ptr[i*PTR_W +: PTR_W]);
  endfunction
  function automatic int hp(input int i);
    return int'(head_ptr[i*PTR_W +: PTR_W]);
  endfunction
  initial begin
    resetn = 1'b0;
    alloc_valid = '0;
    commit_stall = 1'b0;
    wb_clr();
    tick();
    tick();
    resetn = 1'b1;
    #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_ready", 32'(alloc_ready), 1);
    chk("rst_cv", 32'(commit_valid), 0);
    chk("rst_flush", 32'(flush), 0);
    alloc_valid = 2'b11;
    for (int j = 0; j < 3; j++) begin
      #1;
      chk("alloc_p0", ap(0), 2 * j);
      chk("alloc_p1", ap(1), 2 * j + 1);
      tick();
    end
    alloc_valid = 2'b00;
    #1;
    chk("alloc_count6", 32'(count), 6);
    chk("alloc_cv", 32'(commit_valid), 0);
    alloc_valid = 2'b10;
    #1;
    chk("compact_p1", ap(1), 6);
    tick();
    alloc_valid = 2'b00;
    #1;
    chk("compact_count", 32'(count), 7);
    wb_set(0, 1, 1'b0);
    tick();
    wb_clr();
    #1;
    chk("wb_young_only_cv", 32'(commit_valid), 0);
    wb_set(2, 0, 1'b0);
    #1;
    chk("wb_same_cycle_cv", 32'(commit_valid), 0);
    tick();
    wb_clr();
    #1;
    chk("commit_cv", 32'(commit_valid), 3);
    chk("commit_hp0", hp(0), 0);
    chk("commit_hp1", hp(1), 1);
    tick();
    chk("commit_count", 32'(count), 5);
    alloc_valid = 2'b01;
    #1;
    chk("single_p0", ap(0), 7);
    tick();
    alloc_valid = 2'b11;
    for (int j = 0; j < 13; j++) begin
      #1;
      if (j == 11) begin
        chk("prewrap_p0", ap(0), 30);
        chk("prewrap_p1", ap(1), 31);
      end
      if (j == 12) begin
        chk("wrap_p0", ap(0), 0);
        chk("wrap_p1", ap(1), 1);
      end
      tick();
    end
    alloc_valid = 2'b00;
    #1;
    chk("full_count", 32'(count), 32);
    chk("full_ready", 32'(alloc_ready), 0);
    alloc_valid = 2'b11;
    tick();
    alloc_valid = 2'b00;
    #1;
    chk("full_ignore_alloc", 32'(count), 32);
    wb_set(0, 2, 1'b0);
    wb_set(1, 3, 1'b0);
    tick();
    wb_clr();
    #1;
    chk("full_commit_cv", 32'(commit_valid), 3);
    chk("full_commit_ready", 32'(alloc_ready), 0);
    tick();
    chk("after_commit_count", 32'(count), 30);
    chk("after_commit_ready", 32'(alloc_ready), 1);
    wb_set(0, 4, 1'b0);
    wb_set(1, 5, 1'b0);
    commit_stall = 1'b1;
    tick();
    wb_clr();
    #1;
    chk("stall_cv", 32'(commit_valid), 0);
    tick();
    chk("stall_count", 32'(count), 30);
    chk("stall_hp0", hp(0), 4);
    commit_stall = 1'b0;
    #1;
    chk("unstall_cv", 32'(commit_valid), 3);
    tick();
    chk("unstall_count", 32'(count), 28);
    resetn = 1'b0;
    alloc_valid = 2'b11;
    tick();
    resetn = 1'b1;
    alloc_valid = 2'b00;
    #1;
    chk("midrst_count", 32'(count), 0);
    chk("midrst_ready", 32'(alloc_ready), 1);
    chk("midrst_cv", 32'(commit_valid), 0);
    chk("midrst_hp0", hp(0), 0);
    chk("midrst_ap0", ap(0), 0);
    alloc_valid = 2'b11;
    tick();
    tick();
    alloc_valid = 2'b00;
    #1;
    chk("mp_count", 32'(count), 4);
    wb_set(0, 0, 1'b1);
    wb_set(1, 1, 1'b0);
    tick();
    wb_clr();
    #1;
    chk("mp_cv", 32'(commit_valid), 1);
    chk("mp_noflush_yet", 32'(flush), 0);
    tick();
    alloc_valid = 2'b11;
    wb_set(0, 2, 1'b0);
    #1;
    chk("flush_pulse", 32'(flush), 1);
    chk("flush_ready", 32'(alloc_ready), 0);
    chk("flush_cv", 32'(commit_valid), 0);
    chk("flush_count", 32'(count), 3);
    tick();
    alloc_valid = 2'b00;
    wb_clr();
    #1;
    chk("post_flush_count", 32'(count), 0);
    chk("post_flush_flush", 32'(flush), 0);
    chk("post_flush_head", hp(0), 1);
    chk("post_flush_tail", ap(0), 1);
    chk("post_flush_ready", 32'(alloc_ready), 1);
    wb_set(0, 1, 1'b0);
    tick();
    wb_clr();
    alloc_valid = 2'b11;
    #1;
    chk("oor_ap0", ap(0), 1);
    chk("oor_ap1", ap(1), 2);
    tick();
    alloc_valid = 2'b00;
    wb_set(0, 2, 1'b0);
    tick();
    wb_clr();
    #1;
    chk("oor_wb_ignored_cv", 32'(commit_valid), 0);
    chk("oor_count", 32'(count), 2);
    wb_set(0, 1, 1'b0);
    wb_set(3, 1, 1'b1);
    tick();
    wb_clr();
    #1;
    chk("or_flags_cv", 32'(commit_valid), 1);
    tick();
    chk("or_flags_flush", 32'(flush), 1);
    tick();
    chk("or_final_count", 32'(count), 0);
    chk("or_final_head", hp(0), 2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
